ph_bl_fifo_mc: RTL and testbench
================================

Name: ph_bl_fifo_mc

Overview:
- Multi-channel successor to the single-channel pulse-height/baseline FIFO peripheral.
- Accepts pulse-height samples from NUM_CH independent producers and tags each sample with its channel number.
- Merges samples into one shared FIFO and exposes it to the PS through an AXI4-Lite slave with pop-on-read, status, threshold interrupt and drop accounting.
- Sits between the per-pixel pulse-height logic and the AXI interconnect.

Parameters:
- NUM_CH, 4, number of producer channels (1..16).
- DATA_WIDTH, 16, sample width; DATA_WIDTH + clog2(NUM_CH) <= 30 required.
- DEPTH, 512, FIFO entries; power of 2.
- C_S00_AXI_ADDR_WIDTH, 5, AXI4-Lite address width.
- C_S00_AXI_DATA_WIDTH, 32, AXI4-Lite data width; fixed at 32.

Ports:
- s00_axi_aclk  in  1  single clock for all logic.
- s00_axi_aresetn  in  1  synchronous, active-low reset.
- ph_valid  in  NUM_CH  per-channel sample strobe.
- ph_data  in  NUM_CH*DATA_WIDTH  per-channel samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- irq  out  1  level interrupt, high while count >= threshold and threshold != 0.
- s00_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite slave signals: awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready.

Behaviour:
- Reset (synchronous, aresetn low at clock edge) clears:
  - FIFO pointers and count; holding registers; drop counters.
  - CTRL to 0x0000FFFF masked to NUM_CH bits, i.e. all channels enabled.
  - THRESH to 0.
  - All outputs to 0: irq, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp.
- Input capture:
  - One holding register (valid flag + data) per channel.
  - If ph_valid[k], channel k is enabled and hold[k] is empty: capture the sample.
  - If hold[k] is full and not released to the FIFO this cycle: drop the sample and increment DROPS (saturating at 0xFFFFFFFF).
  - Disabled channels ignore ph_valid and are not counted as drops.
- Arbiter:
  - Round-robin over full holding registers; at most one push per cycle.
  - Pointer advances to the winner+1.
  - A push occurs only when the FIFO is not full.
  - Entry format: {ch[clog2(NUM_CH)-1:0], data}.
  - A hold slot freed by the winning push may capture a new sample in the same cycle.
- FIFO:
  - Same-cycle push and pop leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - count range 0..DEPTH.
  - full when count == DEPTH.
- AXI write:
  - awready and wready are asserted together for one cycle when awvalid & wvalid & !bvalid.
  - bvalid rises on the next cycle and holds until bready; bresp = OKAY.
  - wstrb is ignored (full-word writes only).
- AXI read:
  - arready is pulsed for one cycle when arvalid & !rvalid.
  - rdata is registered at the AR handshake; rvalid rises on the next cycle and holds until rready; rresp = OKAY.
  - One outstanding transaction per channel.
- Register map (addr[4:2]):
  - 0x00 DATA (RO):
    - Non-empty FIFO: returns {1'b1 valid at bit31, zeros, ch, data} and pops at the AR handshake.
    - Empty FIFO: returns 0 and does not pop.
  - 0x04 STATUS (RO): [31] full, [30] empty, [29] any hold full, [15:0] count.
  - 0x08 CTRL (RW): [NUM_CH-1:0] channel enable; [16] flush (self-clearing, reads 0).
  - 0x0C DROPS (RO): drop count. Any write to 0x0C clears it; write data is ignored.
  - 0x10 THRESH (RW): [15:0] irq threshold.
  - Other addresses: reads return 0, writes are ignored, response OKAY.
- Flush:
  - In the cycle after the CTRL write with bit16 = 1, FIFO pointers and count go to 0 and all hold registers empty.
  - Flush wins over a push or capture in the same cycle.
  - DROPS is unaffected.
- irq: registered; updates one cycle after a count change.
- Reset mid-transaction: an in-flight bvalid or rvalid is dropped; the master must reissue.

Test Plan:
- Reset then read STATUS -> 0x40000000 (empty); CTRL reads 0x0000000F; irq = 0.
- Single pulse ch2, data 0x1234, then read DATA -> 0x80021234; second read -> 0x00000000; STATUS count 0.
- ph_valid = 4'b1111 in one cycle with data 0x0A..0x0D -> four DATA reads return ch0,1,2,3 in round-robin order; DROPS = 0.
- Hold ch0 valid for 2*DEPTH+4 cycles with no reads -> STATUS = 0x80000000|DEPTH (full, plus hold bit 29 set); DROPS > 0; write 0x0C -> DROPS reads 0.
- THRESH = 3; push 3 samples -> irq high one cycle after the 3rd push; one DATA read -> irq low.
- Write CTRL = 0x00010005 while the FIFO holds 10 entries -> count 0, enable = ch0 and ch2 only; ch1 pulses are ignored and DROPS is unchanged.

Source files
------------

// File: rtl/ph_bl_fifo_mc.sv
// ph_bl_fifo_mc: merges NUM_CH pulse-height producers into one tagged FIFO read over AXI4-Lite.
module ph_bl_fifo_mc #(
  parameter int unsigned NUM_CH               = 4,
  parameter int unsigned DATA_WIDTH           = 16,
  parameter int unsigned DEPTH                = 512,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 5,
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [NUM_CH-1:0]                   ph_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]        ph_data,
  output logic                                irq,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready
);

  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned EntW     = ChW + DATA_WIDTH;
  localparam int unsigned PtrW     = $clog2(DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned DropIncW = $clog2(NUM_CH + 1);

  localparam logic [2:0] RegData   = 3'd0;
  localparam logic [2:0] RegStatus = 3'd1;
  localparam logic [2:0] RegCtrl   = 3'd2;
  localparam logic [2:0] RegDrops  = 3'd3;
  localparam logic [2:0] RegThresh = 3'd4;

  // Per-channel holding registers
  logic [NUM_CH-1:0]     hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_dat_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_dat_d [NUM_CH];
  logic [ChW-1:0]        rr_q, rr_d, win;
  logic                  win_vld;

  // Shared FIFO
  logic [EntW-1:0]       mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  fifo_full, fifo_empty, push, pop;

  // Control / status
  logic [NUM_CH-1:0]     en_q;
  logic                  flush_q;
  logic [31:0]           drops_q, drops_d;
  logic [DropIncW-1:0]   drop_inc;
  logic [32:0]           drops_sum;
  logic [15:0]           thresh_q;
  logic                  irq_q;

  // AXI
  logic                  awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]           rdata_q, rd_val;
  logic                  w_hs, ar_hs;
  logic [2:0]            waddr_idx, raddr_idx;
  logic                  unused;

  assign waddr_idx  = s00_axi_awaddr[4:2];
  assign raddr_idx  = s00_axi_araddr[4:2];
  assign w_hs       = awready_q && s00_axi_awvalid && s00_axi_wvalid;
  assign ar_hs      = arready_q && s00_axi_arvalid;

  assign fifo_full  = (cnt_q == CntW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = win_vld && !fifo_full && !flush_q;
  assign pop        = ar_hs && (raddr_idx == RegData) && !fifo_empty && !flush_q;

  assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb, s00_axi_awaddr,
                    s00_axi_araddr, s00_axi_wdata};

  // Round-robin pick: first full hold slot at or after rr_q (lowest offset wins)
  always_comb begin
    int unsigned idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (hold_vld_q[idx]) begin
        win     = ChW'(idx);
        win_vld = 1'b1;
      end
    end
    rr_d = rr_q;
    if (push) rr_d = (win == ChW'(NUM_CH - 1)) ? '0 : win + 1'b1;
  end

  // Capture/drop: a slot freed by this cycle's push can refill immediately
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    drop_inc   = '0;
    if (push) hold_vld_d[win] = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ph_valid[k] && en_q[k]) begin
        if (!hold_vld_d[k]) begin
          hold_vld_d[k] = 1'b1;
          hold_dat_d[k] = ph_data[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          drop_inc = drop_inc + 1'b1;
        end
      end
    end
    if (flush_q) begin
      hold_vld_d = '0;
      drop_inc   = '0;
    end
  end

  assign drops_sum = {1'b0, drops_q} + 33'(drop_inc);

  // FIFO pointers, count and saturating drop counter
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end
    drops_d = drops_sum[32] ? '1 : drops_sum[31:0];
    if (w_hs && (waddr_idx == RegDrops)) drops_d = '0;
  end

  // Register read mux, sampled at the AR handshake
  always_comb begin
    rd_val = '0;
    case (raddr_idx)
      RegData:   if (!fifo_empty) rd_val = {1'b1, {(31 - EntW){1'b0}}, mem_q[rd_ptr_q]};
      RegStatus: begin
        rd_val[31]   = fifo_full;
        rd_val[30]   = fifo_empty;
        rd_val[29]   = |hold_vld_q;
        rd_val[15:0] = 16'(cnt_q);
      end
      RegCtrl:   rd_val = 32'(en_q);
      RegDrops:  rd_val = drops_q;
      RegThresh: rd_val = 32'(thresh_q);
      default:   rd_val = '0;
    endcase
  end

  // FIFO storage, no reset needed
  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {win, hold_dat_q[win]};
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      hold_vld_q <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_dat_q[k] <= '0;
      rr_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      en_q       <= '1;
      flush_q    <= 1'b0;
      drops_q    <= '0;
      thresh_q   <= '0;
      irq_q      <= 1'b0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drops_q    <= drops_d;
      irq_q      <= (thresh_q != '0) && (32'(cnt_q) >= 32'(thresh_q));
      flush_q    <= w_hs && (waddr_idx == RegCtrl) && s00_axi_wdata[16];
      if (w_hs && (waddr_idx == RegCtrl))   en_q     <= s00_axi_wdata[NUM_CH-1:0];
      if (w_hs && (waddr_idx == RegThresh)) thresh_q <= s00_axi_wdata[15:0];
      // Guard on awready_q/arready_q keeps the ready strobes single-cycle
      awready_q  <= s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !awready_q;
      arready_q  <= s00_axi_arvalid && !rvalid_q && !arready_q;
      if (w_hs)                              bvalid_q <= 1'b1;
      else if (bvalid_q && s00_axi_bready)   bvalid_q <= 1'b0;
      if (ar_hs)                             rvalid_q <= 1'b1;
      else if (rvalid_q && s00_axi_rready)   rvalid_q <= 1'b0;
      if (ar_hs)                             rdata_q  <= rd_val;
    end
  end

  assign irq             = irq_q;
  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_ph_bl_fifo_mc.sv
// Scoreboard bench for ph_bl_fifo_mc: queue-based reference model predicts every read response.
module tb_ph_bl_fifo_mc;
  localparam int NCH   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [NCH-1:0]    ph_valid = '0;
  logic [NCH*DW-1:0] ph_data = '0;
  logic        irq;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  ph_bl_fifo_mc #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .C_S00_AXI_ADDR_WIDTH(5), .C_S00_AXI_DATA_WIDTH(32)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn),
    .ph_valid(ph_valid), .ph_data(ph_data), .irq(irq),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(4'hF),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid), .s00_axi_bready(1'b1),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(1'b1)
  );

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  logic [31:0] last_rdata = '0;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  logic [31:0]    mq[$];
  logic [NCH-1:0] m_hold_v;
  logic [15:0]    m_hold_d [NCH];
  int             m_rr;
  logic [NCH-1:0] m_en;
  logic [31:0]    m_drops;
  logic [15:0]    m_thresh;
  bit             m_flush;
  bit             exp_irq = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    case (idx)
      3'd0: return (mq.size() > 0) ? mq[0] : 32'h0;
      3'd1: return {mq.size() == DEPTH, mq.size() == 0, |m_hold_v, 13'h0, 16'(mq.size())};
      3'd2: return 32'(m_en);
      3'd3: return m_drops;
      3'd4: return 32'(m_thresh);
      default: return 32'h0;
    endcase
  endfunction

  // One clock of the reference model, using the values present at the edge
  task automatic model_step();
    int   pre;
    int   w;
    int   c;
    bit   do_pop;
    exp_t e;
    pre    = mq.size();
    w      = -1;
    do_pop = 1'b0;
    exp_irq = (m_thresh != 0) && (pre >= int'(m_thresh));
    if (arready && arvalid) begin
      e.idx = araddr[4:2];
      e.val = m_read(araddr[4:2]);
      exp_q.push_back(e);
      do_pop = (araddr[4:2] == 3'd0) && (pre > 0);
    end
    if (m_flush) begin
      mq.delete();
      m_hold_v = '0;
      m_flush  = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        c = (m_rr + i) % NCH;
        if (w < 0 && m_hold_v[c]) w = c;
      end
      if (do_pop) void'(mq.pop_front());
      if (w >= 0 && pre < DEPTH) begin
        mq.push_back({1'b1, 13'h0, 2'(w), m_hold_d[w]});
        m_hold_v[w] = 1'b0;
        m_rr = (w + 1) % NCH;
      end
      for (int k = 0; k < NCH; k++) begin
        if (ph_valid[k] && m_en[k]) begin
          if (!m_hold_v[k]) begin
            m_hold_v[k] = 1'b1;
            m_hold_d[k] = ph_data[k*DW +: DW];
          end else if (m_drops != 32'hFFFF_FFFF) begin
            m_drops = m_drops + 1;
          end
        end
      end
    end
    if (awready && awvalid && wvalid) begin
      case (awaddr[4:2])
        3'd2: begin m_en = wdata[NCH-1:0]; m_flush = wdata[16]; end
        3'd3: m_drops = 32'h0;
        3'd4: m_thresh = wdata[15:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!aresetn) begin
        mq.delete();
        m_hold_v = '0;
        m_rr     = 0;
        m_en     = '1;
        m_drops  = 32'h0;
        m_thresh = 16'h0;
        m_flush  = 1'b0;
        exp_irq  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Monitor: pops the scoreboard on every read response
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        resp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rdata_unexpected: got 0x%08h required no response", rdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (rdata !== mon_e.val || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rdata reg%0d: got 0x%08h/%0d required 0x%08h/0", mon_e.idx, rdata,
                     rresp, mon_e.val);
          end
        end
        last_rdata = rdata;
        chk("irq_at_resp", 64'(irq), 64'(exp_irq));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] addr);
    int t;
    int base;
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    base    = resp_cnt;
    t = 0;
    while (arready !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    if (arready !== 1'b1) begin
      chk("ar_handshake", 64'(arready), 64'h1);
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (resp_cnt == base && t < 16) begin @(negedge clk); t++; end
    if (resp_cnt == base) chk("r_timeout", 64'(rvalid), 64'h1);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
    int t;
    @(negedge clk);
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    t = 0;
    while (awready !== 1'b1 && t < 16) begin @(negedge clk); t++; end
    if (awready !== 1'b1) begin
      chk("aw_handshake", 64'(awready), 64'h1);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    chk("wready_with_awready", 64'(wready), 64'h1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("bresp", 64'({bvalid, bresp}), 64'b100);
  endtask

  task automatic pulse(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d);
    @(negedge clk);
    ph_valid = v;
    ph_data  = d;
    @(negedge clk);
    ph_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0;
    idle(2);
    chk("reset_outputs", {22'h0, irq, awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp},
        64'h0);
    aresetn = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    axi_read(5'h04);
    chk("status_after_reset", 64'(last_rdata), 64'h4000_0000);
    axi_read(5'h08);
    chk("ctrl_after_reset", 64'(last_rdata), 64'h0000_000F);
    chk("irq_after_reset", 64'(irq), 64'h0);

    // Single sample on ch2
    pulse(4'b0100, 64'h0000_1234_0000_0000);
    idle(3);
    axi_read(5'h00);
    chk("data_ch2", 64'(last_rdata), 64'h8002_1234);
    axi_read(5'h00);
    chk("data_empty", 64'(last_rdata), 64'h0);
    axi_read(5'h04);
    chk("status_drained", 64'(last_rdata), 64'h4000_0000);

    // All four channels at once, fresh arbiter pointer
    do_reset();
    pulse(4'b1111, 64'h000D_000C_000B_000A);
    idle(6);
    axi_read(5'h00); chk("rr_0", 64'(last_rdata), 64'h8000_000A);
    axi_read(5'h00); chk("rr_1", 64'(last_rdata), 64'h8001_000B);
    axi_read(5'h00); chk("rr_2", 64'(last_rdata), 64'h8002_000C);
    axi_read(5'h00); chk("rr_3", 64'(last_rdata), 64'h8003_000D);
    axi_read(5'h0C); chk("drops_zero", 64'(last_rdata), 64'h0);

    // Fill to full with ch0 continuously valid
    @(negedge clk);
    ph_valid = 4'b0001;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      ph_data[15:0] = 16'(i);
      @(negedge clk);
    end
    ph_valid = '0;
    idle(2);
    axi_read(5'h04);
    chk("status_full", 64'(last_rdata), 64'hA000_0000 | 64'(DEPTH));
    axi_read(5'h0C);
    chk("drops_nonzero", 64'(last_rdata != 0), 64'h1);
    axi_write(5'h0C, $urandom);
    axi_read(5'h0C);
    chk("drops_cleared", 64'(last_rdata), 64'h0);
    axi_write(5'h08, 32'h0001_000F);
    axi_read(5'h04);
    chk("status_after_flush", 64'(last_rdata), 64'h4000_0000);

    // Threshold interrupt
    axi_write(5'h10, 32'd3);
    pulse(4'b0010, 64'h0000_0000_1111_0000);
    pulse(4'b0010, 64'h0000_0000_2222_0000);
    pulse(4'b0010, 64'h0000_0000_3333_0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("irq_track", 64'(irq), 64'(exp_irq));
    end
    chk("irq_high", 64'(irq), 64'h1);
    axi_read(5'h00);
    chk("irq_pop_data", 64'(last_rdata), 64'h8001_1111);
    idle(2);
    chk("irq_low", 64'(irq), 64'h0);

    // Flush with 10 entries and channel-enable change
    axi_write(5'h08, 32'h0001_000F);
    @(negedge clk);
    ph_valid = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      ph_data = {$urandom, $urandom};
      @(negedge clk);
    end
    ph_valid = '0;
    idle(3);
    axi_read(5'h04);
    chk("status_ten", 64'(last_rdata), 64'h0000_000A);
    axi_write(5'h08, 32'h0001_0005);
    axi_read(5'h04);
    chk("status_flushed", 64'(last_rdata), 64'h4000_0000);
    axi_read(5'h08);
    chk("ctrl_ch0_ch2", 64'(last_rdata), 64'h0000_0005);
    pulse(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse(4'b0010, 64'h1234_5678_9ABC_DEF0);
    idle(2);
    axi_read(5'h04);
    chk("ch1_ignored", 64'(last_rdata), 64'h4000_0000);
    axi_read(5'h0C);
    chk("drops_unchanged", 64'(last_rdata), 64'h0);

    // Randomized traffic against the model
    axi_write(5'h08, 32'h0000_000F);
    fork
      begin
        for (int c = 0; c < 800; c++) begin
          @(negedge clk);
          ph_valid = NCH'($urandom & $urandom);
          ph_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        ph_valid = '0;
      end
      begin
        for (int n = 0; n < 150; n++) begin
          int r;
          int a;
          r = $urandom_range(0, 9);
          a = $urandom_range(0, 7);
          if (r < 6) axi_read(5'h00);
          else if (r < 8) axi_read(5'(a << 2));
          else if (a == 4) axi_write(5'h10, 32'($urandom_range(0, 12)));
          else axi_write(5'(a << 2), $urandom & 32'hFFFE_FFFF);
        end
      end
    join
    idle(5);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
